// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dm_state_e;

    // All byte enables inactive means the request is a read.
    localparam logic [3:0] WEB_READ = 4'b1111;

    // Largest wait-state count the 3-bit counter can represent.
    localparam int MAX_WAIT = 7;

    // True when the active-low byte enables describe a read.
    function automatic logic is_read(input logic [3:0] web);
        return web == WEB_READ;
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// DM bus between the MEM stage (master) and the data-memory responder (slave).
interface dm_responder_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic                  CS;
    logic [3:0]            WEB;
    logic [ADDR_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] DI;
    logic [DATA_WIDTH-1:0] DO;
    logic                  stall;

    modport master (output CS, WEB, A, DI, input DO, stall);
    modport slave  (input CS, WEB, A, DI, output DO, stall);
endinterface

// File: rtl/dm_sram_array.sv
// Single-port word array with per-byte write enables and a registered read port.
// Contents are never reset; only the read register clears on reset.
module dm_sram_array #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // Byte-masked write; lanes with be low keep their old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read register: loads only on a completing read, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: serves one DM request at a time with a fixed number
// of wait states and stalls the MEM stage until the request completes.
// Optional feature: define DM_PERF_CNT_EN to add read/write/stall counters.
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    dm_responder_if.slave bus
`ifdef DM_PERF_CNT_EN
    ,
    output logic [31:0]   rd_cnt,
    output logic [31:0]   wr_cnt,
    output logic [31:0]   stall_cnt
`endif
);
    // Out-of-range wait counts are clamped to what the counter can hold.
    localparam int WAIT_EFF = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT :
                              (WAIT_CYCLES < 0) ? 0 : WAIT_CYCLES;
    localparam logic [2:0] WAIT_LOAD = (WAIT_EFF > 0) ? 3'(WAIT_EFF - 1) : 3'd0;

    dm_state_e             state;
    logic [2:0]            cnt;
    logic [3:0]            req_web;
    logic [ADDR_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_di;

    logic                  accept;
    logic                  finish;
    logic [3:0]            cur_web;
    logic [ADDR_WIDTH-1:0] cur_a;
    logic [DATA_WIDTH-1:0] cur_di;
    logic                  commit_wr;
    logic                  commit_rd;

    assign accept = (state == IDLE) && bus.CS;

    // With zero wait states the request completes straight from IDLE, before
    // the request registers have been loaded, so the live bus is used there.
    assign cur_web = (state == IDLE) ? bus.WEB : req_web;
    assign cur_a   = (state == IDLE) ? bus.A   : req_a;
    assign cur_di  = (state == IDLE) ? bus.DI  : req_di;

    // The edge entering DONE; reset held high must never commit an access.
    assign finish = !rst && ((accept && (WAIT_EFF == 0)) ||
                             ((state == WAIT) && (cnt == 3'd0)));

    assign commit_wr = finish && !is_read(cur_web);
    assign commit_rd = finish &&  is_read(cur_web);

    assign bus.stall = accept || (state == WAIT);

    // Request sequencing: IDLE -> (WAIT) -> DONE -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.CS) begin
                        cnt   <= WAIT_LOAD;
                        state <= (WAIT_EFF > 0) ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the request so later bus changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_web <= bus.WEB;
            req_a   <= bus.A;
            req_di  <= bus.DI;
        end
    end

    dm_sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (commit_wr),
        .be    (~cur_web),
        .re    (commit_rd),
        .addr  (cur_a),
        .wdata (cur_di),
        .rdata (bus.DO)
    );

`ifdef DM_PERF_CNT_EN
    // Activity counters; all wrap naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == DONE) begin
                if (is_read(req_web)) begin
                    rd_cnt <= rd_cnt + 32'd1;
                end else begin
                    wr_cnt <= wr_cnt + 32'd1;
                end
            end
            if (bus.stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
